mdu_issue_sel: RTL and testbench

//  Consumer side of the MDU issue queue: selects, dequeues and issues one MDU op per cycle.

---
 rtl/mdu_issue_sel_pkg.sv | 32 +++
 rtl/mdu_issue_sel_hilo_scoreboard.sv | 44 ++++
 rtl/mdu_issue_sel.sv | 88 ++++++++
 tb/tb_mdu_issue_sel.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_issue_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module : mdu_issue_sel_pkg
// Brief  : Shared MDU issue types, latency constants and hazard helper.
// Rev    : 1.0
// ============================================================================
package mdu_issue_sel_pkg;

    localparam int MDU_MUL_LAT = 3;
    localparam int MDU_DIV_LAT = 34;

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_DIV  = 2'd1,
        OP_MFHL = 2'd2,
        OP_MTHL = 2'd3
    } MDU_Op_Cls;

    typedef struct packed {
        MDU_Op_Cls   op_cls;
        logic        is_signed;
        logic [5:0]  tag;
    } MDU_Queue_Meta;

    // Multiplies only collide with the divider; everything else needs HI/LO idle.
    function automatic logic hz_ok(input MDU_Op_Cls cls, input logic div_pend,
                                   input logic hilo_busy);
        return (cls == OP_MUL) ? !div_pend : !hilo_busy;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_issue_sel_hilo_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : mdu_hilo_scoreboard
// Brief  : Tracks the iterative divider and in-flight multiplies writing HI/LO.
// Rev    : 1.0
// ============================================================================
module mdu_hilo_scoreboard #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 34,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mul_start,
    input  logic div_start,
    input  logic kill,
    output logic div_busy,
    output logic mul_busy
);

    logic [CNT_W-1:0]   div_cnt;
    logic [MUL_LAT-1:0] mul_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            mul_sr  <= '0;
        end else if (kill) begin
            div_cnt <= '0;
            mul_sr  <= '0;
        end else begin
            mul_sr <= {mul_sr[MUL_LAT-2:0], mul_start};
            if (div_start)
                div_cnt <= CNT_W'(DIV_LAT);
            else if (div_cnt != '0)
                div_cnt <= div_cnt - CNT_W'(1);
        end
    end

    assign div_busy = (div_cnt != '0);
    assign mul_busy = (mul_sr != '0);

endmodule
`default_nettype wire

// File: rtl/mdu_issue_sel.sv
`default_nettype none
// ============================================================================
// Module : mdu_issue_sel
// Brief  : In-order MDU issue select with HI/LO hazard tracking and issue reg.
// Rev    : 1.0
// ============================================================================
module mdu_issue_sel
    import mdu_issue_sel_pkg::*;
#(
    parameter int QLEN    = 8,
    parameter int IDX_W   = 3,
    parameter int MUL_LAT = MDU_MUL_LAT,
    parameter int DIV_LAT = MDU_DIV_LAT,
    parameter int CNT_W   = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [QLEN-1:0] valid_vec,
    input  logic [QLEN-1:0] ready_vec,
    input  MDU_Queue_Meta   head_meta,
    output logic            deq_req_0,
    output logic            deq_req_1,
    output logic [IDX_W-1:0] deq0_idx,
    output logic [IDX_W-1:0] deq1_idx,
    output logic            issue_valid,
    output MDU_Queue_Meta   issue_meta,
    input  logic            issue_ready,
    output logic            div_busy,
    output logic            hilo_busy
);

    logic isq_mul;
    logic isq_div;
    logic div_pend;
    logic mul_busy;
    logic handshake;
    logic fire;
    logic unused_vec;

    assign isq_mul   = issue_valid && (issue_meta.op_cls == OP_MUL);
    assign isq_div   = issue_valid && (issue_meta.op_cls == OP_DIV);
    assign div_pend  = isq_div || div_busy;
    assign hilo_busy = div_pend || isq_mul || mul_busy;
    assign handshake = issue_valid && issue_ready && !flush;

    // Only entry 0 may leave, keeping HI/LO accesses in program order.
    assign fire = rst_n && valid_vec[0] && ready_vec[0]
               && hz_ok(head_meta.op_cls, div_pend, hilo_busy)
               && (!issue_valid || issue_ready) && !flush;

    assign deq_req_0 = fire;
    assign deq_req_1 = 1'b0;
    assign deq0_idx  = '0;
    assign deq1_idx  = '0;

    assign unused_vec = ^{valid_vec[QLEN-1:1], ready_vec[QLEN-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid <= 1'b0;
            issue_meta  <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else if (fire) begin
            issue_valid <= 1'b1;
            issue_meta  <= head_meta;
        end else if (issue_ready) begin
            issue_valid <= 1'b0;
        end
    end

    mdu_hilo_scoreboard #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .mul_start (handshake && (issue_meta.op_cls == OP_MUL)),
        .div_start (handshake && (issue_meta.op_cls == OP_DIV)),
        .kill      (flush),
        .div_busy  (div_busy),
        .mul_busy  (mul_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue_sel.sv
`default_nettype none
// ============================================================================
// Module : tb_mdu_issue_sel
// Brief  : Directed scoreboard bench for mdu_issue_sel.
// Rev    : 1.0
// ============================================================================
module tb_mdu_issue_sel;
    import mdu_issue_sel_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [7:0]    valid_vec;
    logic [7:0]    ready_vec;
    MDU_Queue_Meta head_meta;
    logic          deq_req_0;
    logic          deq_req_1;
    logic [2:0]    deq0_idx;
    logic [2:0]    deq1_idx;
    logic          issue_valid;
    MDU_Queue_Meta issue_meta;
    logic          issue_ready;
    logic          div_busy;
    logic          hilo_busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic head_rdy;
    logic deq_seen;
    MDU_Queue_Meta qm[$];
    MDU_Queue_Meta expq[$];

    mdu_issue_sel dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .valid_vec   (valid_vec),
        .ready_vec   (ready_vec),
        .head_meta   (head_meta),
        .deq_req_0   (deq_req_0),
        .deq_req_1   (deq_req_1),
        .deq0_idx    (deq0_idx),
        .deq1_idx    (deq1_idx),
        .issue_valid (issue_valid),
        .issue_meta  (issue_meta),
        .issue_ready (issue_ready),
        .div_busy    (div_busy),
        .hilo_busy   (hilo_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < qm.size() && i < 8; i++) v[i] = 1'b1;
        valid_vec = v;
        ready_vec = head_rdy ? v : (v & 8'hFE);
        head_meta = (qm.size() != 0) ? qm[0] : '0;
    endtask

    task automatic load(input MDU_Op_Cls c, input logic [5:0] t);
        MDU_Queue_Meta m;
        m = '0;
        m.op_cls = c;
        m.tag = t;
        qm.push_back(m);
        expq.push_back(m);
        drive();
    endtask

    // Queue model: a dequeue seen in a cycle removes the head at the next edge.
    task automatic tick();
        @(negedge clk) deq_seen = deq_req_0;
        @(posedge clk);
        #1;
        if (deq_seen && qm.size() != 0) void'(qm.pop_front());
        drive();
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((qm.size() != 0 || issue_valid || hilo_busy) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: queue %0d issue_valid %0b hilo_busy %0b", qm.size(), issue_valid, hilo_busy);
        end
    endtask

    // Every accepted issue must match the oldest outstanding loaded op.
    always @(negedge clk) begin
        if (rst_n && !flush && issue_valid && issue_ready) begin
            if (expq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL issue_unexpected: got %0h expected none", issue_meta);
            end else begin
                check("issue_order", 32'(issue_meta), 32'(expq.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic bad;
        logic [7:0] pat;
        rst_n = 1'b0; flush = 1'b0; issue_ready = 1'b1; head_rdy = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_issue_valid", issue_valid, 0);
        check("rst_issue_meta", 32'(issue_meta), 0);
        check("rst_deq", deq_req_0, 0);
        check("rst_div_busy", div_busy, 0);
        check("rst_hilo_busy", hilo_busy, 0);

        // Single MUL out of reset
        load(OP_MUL, 6'd1);
        #1 check("rst_no_deq", deq_req_0, 0);
        rst_n = 1'b1;
        #1 check("t1_deq_c0", deq_req_0, 1);
        tick();
        check("t1_valid_c1", issue_valid, 1);
        check("t1_cls_c1", 32'(issue_meta.op_cls), 32'(OP_MUL));
        tick();
        check("t1_mulsr_c2", 32'(dut.u_sb.mul_sr), 32'h1);
        check("t1_hilo_c2", hilo_busy, 1);
        wait_idle();

        // DIV then MUL: MUL held until the divider counter expires
        load(OP_DIV, 6'd2);
        load(OP_MUL, 6'd3);
        #1 check("t2_div_fire", deq_req_0, 1);
        tick();
        check("t2_mul_blocked_c1", deq_req_0, 0);
        bad = 1'b0;
        repeat (34) begin
            tick();
            if (deq_req_0) bad = 1'b1;
        end
        check("t2_mul_held", bad, 0);
        check("t2_div_busy_c35", div_busy, 1);
        tick();
        check("t2_mul_fire_c36", deq_req_0, 1);
        check("t2_div_idle_c36", div_busy, 0);
        wait_idle();

        // Back-to-back MULs, then MFHL waits for the multiply pipe
        load(OP_MUL, 6'd4);
        load(OP_MUL, 6'd5);
        load(OP_MUL, 6'd6);
        load(OP_MFHL, 6'd7);
        #1 pat[0] = deq_req_0;
        for (int i = 1; i < 8; i++) begin
            tick();
            pat[i] = deq_req_0;
        end
        check("t3_fire_pattern", 32'(pat), 32'h87);
        wait_idle();

        // Head not ready while a younger entry is ready
        head_rdy = 1'b0;
        load(OP_MUL, 6'd20);
        load(OP_MUL, 6'd21);
        #1 check("hd_notready_c0", deq_req_0, 0);
        tick();
        check("hd_notready_c1", deq_req_0, 0);
        head_rdy = 1'b1;
        drive();
        #1 check("hd_ready", deq_req_0, 1);
        wait_idle();

        // Backpressure, then same-cycle refill
        issue_ready = 1'b0;
        load(OP_MTHL, 6'd8);
        load(OP_MUL, 6'd9);
        #1 check("t4_deq_c0", deq_req_0, 1);
        tick();
        check("t4_valid_c1", issue_valid, 1);
        bad = 1'b0;
        repeat (4) begin
            if (deq_req_0 || issue_meta.tag != 6'd8 || !issue_valid) bad = 1'b1;
            tick();
        end
        check("t4_stall_stable", bad, 0);
        issue_ready = 1'b1;
        #1 check("t4_refill_deq", deq_req_0, 1);
        tick();
        check("t4_new_meta", 32'(issue_meta.tag), 9);
        check("t4_new_valid", issue_valid, 1);
        wait_idle();

        // Flush while the divider is counting
        load(OP_DIV, 6'd10);
        #1;
        tick();
        load(OP_DIV, 6'd11);
        tick();
        repeat (14) tick();
        check("t5_cnt20", 32'(dut.u_sb.div_cnt), 20);
        flush = 1'b1;
        #1 check("t5_flush_deq", deq_req_0, 0);
        tick();
        flush = 1'b0;
        drive();
        #1;
        check("t5_div_busy_clr", div_busy, 0);
        check("t5_valid_clr", issue_valid, 0);
        check("t5_div_refire", deq_req_0, 1);
        wait_idle();

        // Flush with the issue register full overrides a concurrent fire
        issue_ready = 1'b0;
        load(OP_MFHL, 6'd12);
        #1;
        tick();
        check("t5b_full", issue_valid, 1);
        expq.delete(0);
        load(OP_MUL, 6'd13);
        issue_ready = 1'b1;
        flush = 1'b1;
        #1 check("t5b_flush_forces_deq0", deq_req_0, 0);
        tick();
        flush = 1'b0;
        drive();
        #1;
        check("t5b_valid_clr", issue_valid, 0);
        check("t5b_mul_fire", deq_req_0, 1);
        wait_idle();

        // Asynchronous reset in the middle of a divide
        load(OP_DIV, 6'd14);
        #1;
        tick();
        load(OP_DIV, 6'd15);
        tick();
        check("t6_div_running", div_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_div_busy", div_busy, 0);
        check("t6_hilo_busy", hilo_busy, 0);
        check("t6_issue_valid", issue_valid, 0);
        check("t6_div_cnt", 32'(dut.u_sb.div_cnt), 0);
        check("t6_no_deq_in_rst", deq_req_0, 0);
        tick();
        tick();
        check("t6_hold_rst", deq_req_0 | issue_valid, 0);
        rst_n = 1'b1;
        #1 check("t6_fire_after_rst", deq_req_0, 1);
        wait_idle();

        check("scoreboard_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
